// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and default constants for the AXI-Lite->APB read/write arbiter.
//   arb_state_e : arbiter FSM states (IDLE, W_GNT, R_GNT)
//   path_e      : which AXI path was served last (drives round-robin fairness)
//   *_DEF       : default parameter values used by apb_rw_arbiter / apb_arb_timer
// -----------------------------------------------------------------------------
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    W_GNT = 2'd1,
    R_GNT = 2'd2
  } arb_state_e;

  typedef enum logic {
    PATH_WRITE = 1'b0,
    PATH_READ  = 1'b1
  } path_e;

  localparam int MAX_WR_BURST_DEF   = 4;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  // Path owning the APB while the FSM sits in a grant state.
  function automatic path_e served_path(input arb_state_e s);
    return (s == R_GNT) ? PATH_READ : PATH_WRITE;
  endfunction

endpackage

// File: rtl/apb_arb_timer.sv
// -----------------------------------------------------------------------------
// apb_arb_timer
// Grant watchdog: counts cycles while a grant is active and flags expiry once
// CYCLES grant cycles have elapsed without the owner finishing.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset
//   i_clear  in  restart the count (asserted on the edge that enters a grant)
//   i_run    in  a grant is active this cycle
//   o_expire out combinational: this is the last allowed grant cycle
// -----------------------------------------------------------------------------
module apb_arb_timer
  import apb_arb_pkg::*;
#(
  parameter int CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // The count parks at LAST after expiry; the next grant entry clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = i_run && (r_cnt == LAST);

endmodule

// File: rtl/apb_rw_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rw_arbiter
// Arbitrates the single APB master of the AXI-Lite->APB bridge between the
// write path (AW+W ready) and the read path (AR pending). One exclusive grant
// is issued at a time and held until the APB FSM pulses done; a per-path
// completion pulse is returned to the AXI side.
//
// Optional feature macro: APB_ARB_TIMEOUT_EN
//   defined   : a grant not finished within TIMEOUT_CYCLES cycles is aborted
//               and timeout_err pulses for one cycle (no *_done pulse).
//   undefined : grants are held indefinitely; timeout_err is tied 0.
//
// Ports:
//   apb_axi_clk in  clock, rising edge
//   a_reset     in  synchronous active-high reset
//   w_req       in  write path requests APB (level)
//   r_req       in  read path requests APB (level)
//   prio_mode   in  0 = round-robin, 1 = write priority bounded by MAX_WR_BURST
//   done        in  1-cycle pulse: granted APB transfer finished
//   w_grant     out write path owns APB (registered)
//   r_grant     out read path owns APB (registered)
//   w_done      out 1-cycle pulse: write transfer completed
//   r_done      out 1-cycle pulse: read transfer completed
//   busy        out a grant is active
//   timeout_err out 1-cycle pulse on grant abort
// -----------------------------------------------------------------------------
module apb_rw_arbiter
  import apb_arb_pkg::*;
#(
  parameter int MAX_WR_BURST   = MAX_WR_BURST_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic apb_axi_clk,
  input  logic a_reset,
  input  logic w_req,
  input  logic r_req,
  input  logic prio_mode,
  input  logic done,
  output logic w_grant,
  output logic r_grant,
  output logic w_done,
  output logic r_done,
  output logic busy,
  output logic timeout_err
);

  localparam int BW = $clog2(MAX_WR_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WR_BURST);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  path_e         r_last_served;
  logic [BW-1:0] r_wr_burst_cnt;
  logic          r_w_done;
  logic          r_r_done;

  logic          w_expire;
  logic          w_wr_fin;
  logic          w_rd_fin;
  logic          w_abort;

  function automatic logic [BW-1:0] burst_sat_inc(input logic [BW-1:0] cnt);
    return (cnt == BURST_MAX) ? cnt : cnt + BW'(1);
  endfunction

  // done takes precedence over an expiry landing in the same cycle.
  assign w_wr_fin = (r_state == W_GNT) && done;
  assign w_rd_fin = (r_state == R_GNT) && done;
  assign w_abort  = (r_state != IDLE) && !done && w_expire;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        // done seen here belongs to no grant and is dropped.
        if (w_req && r_req) begin
          if (prio_mode) begin
            w_state_nxt = (r_wr_burst_cnt == BURST_MAX) ? R_GNT : W_GNT;
          end else begin
            w_state_nxt = (r_last_served == PATH_READ) ? W_GNT : R_GNT;
          end
        end else if (w_req) begin
          w_state_nxt = W_GNT;
        end else if (r_req) begin
          w_state_nxt = R_GNT;
        end
      end
      W_GNT, R_GNT: begin
        // Request level is ignored while granted; only done/abort release.
        if (done || w_abort) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge apb_axi_clk) begin
    if (a_reset) begin
      r_state        <= IDLE;
      r_last_served  <= PATH_READ;
      r_wr_burst_cnt <= '0;
      r_w_done       <= 1'b0;
      r_r_done       <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_w_done <= w_wr_fin;
      r_r_done <= w_rd_fin;
      if (w_wr_fin || w_rd_fin || w_abort) begin
        r_last_served <= served_path(r_state);
      end
      // Burst count tracks writes that starved a waiting reader.
      if (w_rd_fin) begin
        r_wr_burst_cnt <= '0;
      end else if (w_wr_fin) begin
        r_wr_burst_cnt <= r_req ? burst_sat_inc(r_wr_burst_cnt) : '0;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic r_timeout_err;

  apb_arb_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (apb_axi_clk),
    .rst      (a_reset),
    .i_clear  ((r_state == IDLE) && (w_state_nxt != IDLE)),
    .i_run    (r_state != IDLE),
    .o_expire (w_expire)
  );

  always_ff @(posedge apb_axi_clk) begin
    if (a_reset) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_abort;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_tmo;

  assign w_expire     = 1'b0;
  assign timeout_err  = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  // Grants decode straight from the state register, so they are registered.
  assign w_grant = (r_state == W_GNT);
  assign r_grant = (r_state == R_GNT);
  assign busy    = w_grant | r_grant;
  assign w_done  = r_w_done;
  assign r_done  = r_r_done;

endmodule

// File: tb/tb_apb_rw_arbiter.sv
module tb_apb_rw_arbiter;

  logic apb_axi_clk = 1'b0;
  logic a_reset     = 1'b1;
  logic w_req       = 1'b0;
  logic r_req       = 1'b0;
  logic prio_mode   = 1'b0;
  logic done        = 1'b0;
  logic w_grant, r_grant, w_done, r_done, busy, timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int sbq[$];   // expected grant sequence: 0 = write, 1 = read

  apb_rw_arbiter #(
    .MAX_WR_BURST   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .apb_axi_clk (apb_axi_clk),
    .a_reset     (a_reset),
    .w_req       (w_req),
    .r_req       (r_req),
    .prio_mode   (prio_mode),
    .done        (done),
    .w_grant     (w_grant),
    .r_grant     (r_grant),
    .w_done      (w_done),
    .r_done      (r_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 apb_axi_clk = ~apb_axi_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge apb_axi_clk);
    #1;
  endtask

  task automatic do_reset();
    a_reset = 1'b1;
    w_req = 1'b0; r_req = 1'b0; done = 1'b0; prio_mode = 1'b0;
    tick(); tick();
    a_reset = 1'b0;
  endtask

  // Serves n grants from the scoreboard; done is pulsed so each grant lasts dly cycles.
  task automatic serve_grants(input int n, input int dly);
    int waited;
    int exp_p;
    int got_p;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      while (!(w_grant || r_grant) && waited < 20) begin
        tick();
        waited++;
      end
      n_cmp++;
      if (!(w_grant || r_grant)) begin
        n_fail++;
        $display("FAIL grant_wait[%0d]: no grant after %0d cycles, required a grant", i, waited);
        return;
      end
      if (i > 0) begin
        n_cmp++;
        if (waited !== 1) begin
          n_fail++;
          $display("FAIL idle_spacing[%0d]: idle cycles %0d, required 1", i, waited);
        end
      end
      exp_p = (sbq.size() > 0) ? sbq.pop_front() : -1;
      got_p = r_grant ? 1 : 0;
      n_cmp++;
      if (got_p !== exp_p) begin
        n_fail++;
        $display("FAIL grant_seq[%0d]: got path %0d, required path %0d (0=W,1=R)", i, got_p, exp_p);
      end
      n_cmp++;
      if ((w_grant & r_grant) !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL grant_excl[%0d]: w_grant=%b r_grant=%b busy=%b, required one grant and busy=1",
                 i, w_grant, r_grant, busy);
      end
      for (int c = 1; c < dly; c++) begin
        tick();
        n_cmp++;
        if (w_grant !== (got_p == 0) || r_grant !== (got_p == 1)) begin
          n_fail++;
          $display("FAIL grant_hold[%0d]: w_grant=%b r_grant=%b, required grant held on path %0d",
                   i, w_grant, r_grant, got_p);
        end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_cmp++;
      if (w_done !== (got_p == 0) || r_done !== (got_p == 1)) begin
        n_fail++;
        $display("FAIL done_pulse[%0d]: w_done=%b r_done=%b, required pulse on path %0d",
                 i, w_done, r_done, got_p);
      end
      n_cmp++;
      if (w_grant !== 1'b0 || r_grant !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_gap[%0d]: w_grant=%b r_grant=%b busy=%b, required all 0",
                 i, w_grant, r_grant, busy);
      end
    end
  endtask

  task automatic test_reset();
    a_reset = 1'b1;
    w_req = 1'b0; r_req = 1'b0; done = 1'b0; prio_mode = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if ({w_grant, r_grant, w_done, r_done, busy, timeout_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {w_grant, r_grant, w_done, r_done, busy, timeout_err});
    end
    a_reset = 1'b0;
    w_req = 1'b1; r_req = 1'b1;
    sbq.push_back(0);
    sbq.push_back(1);
    tick();
    n_cmp++;
    if (w_grant !== 1'b1 || r_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL first_grant: w_grant=%b r_grant=%b, required 1/0", w_grant, r_grant);
    end
    serve_grants(2, 1);
    w_req = 1'b0; r_req = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    prio_mode = 1'b0;
    w_req = 1'b1; r_req = 1'b1;
    for (int i = 0; i < 4; i++) sbq.push_back(i % 2);
    serve_grants(4, 3);
    w_req = 1'b0; r_req = 1'b0;
  endtask

  task automatic test_write_priority();
    do_reset();
    prio_mode = 1'b1;
    w_req = 1'b1; r_req = 1'b1;
    for (int i = 0; i < 10; i++) sbq.push_back((i % 5 == 4) ? 1 : 0);
    serve_grants(10, 2);
    w_req = 1'b0; r_req = 1'b0;
    prio_mode = 1'b0;
  endtask

  task automatic test_idle_done_and_reset();
    do_reset();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++;
    if ({w_grant, r_grant, w_done, r_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_done: grants/dones %b, required 0000", {w_grant, r_grant, w_done, r_done});
    end
    tick();
    n_cmp++;
    if ({w_grant, r_grant, w_done, r_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_done_late: grants/dones %b, required 0000", {w_grant, r_grant, w_done, r_done});
    end
    w_req = 1'b1;
    tick();
    n_cmp++;
    if (w_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_setup: w_grant=%b, required 1", w_grant);
    end
    a_reset = 1'b1;
    tick();
    n_cmp++;
    if (w_grant !== 1'b0 || w_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_drop: w_grant=%b w_done=%b, required 0/0", w_grant, w_done);
    end
    a_reset = 1'b0;
    w_req = 1'b0;
    tick();
    n_cmp++;
    if (w_done !== 1'b0 || w_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_after: w_done=%b w_grant=%b, required 0/0", w_done, w_grant);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    logic saw_rdone;
    do_reset();
    r_req = 1'b1;
    tick();
    n_cmp++;
    if (r_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_grant: r_grant=%b, required 1", r_grant);
    end
    cnt = 0;
    saw_rdone = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    while (r_grant && cnt < 200) begin
      if (r_done) saw_rdone = 1'b1;
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 8) begin
      n_fail++;
      $display("FAIL tmo_len: grant cycles %0d, required 8", cnt);
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || r_done !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_pulse: timeout_err=%b r_done=%b, required 1/0", timeout_err, r_done);
    end
    r_req = 1'b0;
    tick();
    n_cmp++;
    if (timeout_err !== 1'b0 || r_done !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_single: timeout_err=%b r_done=%b, required 0/0", timeout_err, r_done);
    end
`else
    while (r_grant && cnt < 100) begin
      if (r_done || timeout_err) saw_rdone = 1'b1;
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 100 || r_grant !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_hold: held %0d r_grant=%b timeout_err=%b, required 100/1/0",
               cnt, r_grant, timeout_err);
    end
    r_req = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++;
    if (r_done !== 1'b1 || r_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_release: r_done=%b r_grant=%b, required 1/0", r_done, r_grant);
    end
`endif
    n_cmp++;
    if (saw_rdone !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_no_done: stray r_done/timeout_err seen=%b, required 0", saw_rdone);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    w_req = 1'b1;
    sbq.push_back(0);
    tick();
    w_req = 1'b0;
    serve_grants(1, 4);
    tick();
    n_cmp++;
    if (w_grant !== 1'b0 || r_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL req_drop_idle: w_grant=%b r_grant=%b, required 0/0", w_grant, r_grant);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_priority();
    test_idle_done_and_reset();
    test_timeout();
    test_req_drop();
    n_cmp++;
    if (sbq.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
